// File: rtl/score_bcd_ctrl_pkg.sv
// rtl/score_bcd_ctrl_pkg.sv - shared types and constants for the score BCD controller
package score_bcd_ctrl_pkg;

    localparam int SCORE_W  = 8;
    localparam int BCD_W    = 4;
    localparam int N_DIGITS = 3;
    localparam int N_ITER   = 8;
    localparam int SH_W     = SCORE_W + BCD_W * N_DIGITS;
    localparam int CNT_W    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    // Leading-zero blanking: ones is always lit so a zero score still shows "0".
    function automatic logic [N_DIGITS-1:0] lz_mask(input logic blank_lz,
                                                    input logic [BCD_W-1:0] hun,
                                                    input logic [BCD_W-1:0] ten);
        logic [N_DIGITS-1:0] m;
        if (blank_lz) begin
            m = {hun != '0, (hun != '0) || (ten != '0), 1'b1};
        end else begin
            m = '1;
        end
        return m;
    endfunction

endpackage

// File: rtl/score_bcd_ctrl_if.sv
// rtl/score_bcd_ctrl_if.sv - score in / digits out bundle between score counter, controller and scan driver
interface score_bcd_ctrl_if;
    import score_bcd_ctrl_pkg::*;

    logic [SCORE_W-1:0]  score;
    logic                req;
    logic                ready;
    logic                busy;
    logic                done;
    logic [BCD_W-1:0]    one;
    logic [BCD_W-1:0]    ten;
    logic [BCD_W-1:0]    hun;
    logic [N_DIGITS-1:0] digit_en;

    modport master (
        output score, req,
        input  ready, busy, done, one, ten, hun, digit_en
    );

    modport slave (
        input  score, req,
        output ready, busy, done, one, ten, hun, digit_en
    );

endinterface

// File: rtl/score_bcd_ctrl_bcd_add3.sv
// rtl/score_bcd_ctrl_bcd_add3.sv - double-dabble correction cell: add 3 when the digit is 5 or more
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/score_bcd_ctrl.sv
// rtl/score_bcd_ctrl.sv - iterative binary-to-BCD converter feeding the 3-digit score display
module score_bcd_ctrl
    import score_bcd_ctrl_pkg::*;
#(
    parameter bit AUTO_UPDATE = 1'b1,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic              clk_out,
    input  logic              rst_n,
    score_bcd_ctrl_if.slave   bus
);

    state_e              state_q, state_d;
    logic [SH_W-1:0]     sh_q, sh_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SCORE_W-1:0]  last_q, last_d;
    logic [BCD_W-1:0]    one_q, one_d;
    logic [BCD_W-1:0]    ten_q, ten_d;
    logic [BCD_W-1:0]    hun_q, hun_d;
    logic [N_DIGITS-1:0] en_q, en_d;
    logic                done_q, done_d;

    logic [SH_W-1:0]     sh_adj;
    logic [SH_W-1:0]     sh_shift;
    logic                start;

    // Correct every BCD field before the shift; the binary part passes through.
    assign sh_adj[SCORE_W-1:0] = sh_q[SCORE_W-1:0];

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (sh_q  [SCORE_W + g*BCD_W +: BCD_W]),
            .dout (sh_adj[SCORE_W + g*BCD_W +: BCD_W])
        );
    end

    assign sh_shift = sh_adj << 1;

    assign start = AUTO_UPDATE ? (bus.score != last_q) : bus.req;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        one_d   = one_q;
        ten_d   = ten_q;
        hun_d   = hun_q;
        en_d    = en_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sh_d    = {{(BCD_W*N_DIGITS){1'b0}}, bus.score};
                    last_d  = bus.score;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                sh_d  = sh_shift;
                cnt_d = cnt_q + 1'b1;
                // All three digits and the mask land together on the final iteration.
                if (cnt_q == CNT_W'(N_ITER - 1)) begin
                    hun_d   = sh_shift[SCORE_W + 2*BCD_W +: BCD_W];
                    ten_d   = sh_shift[SCORE_W + 1*BCD_W +: BCD_W];
                    one_d   = sh_shift[SCORE_W +: BCD_W];
                    en_d    = lz_mask(BLANK_LZ,
                                      sh_shift[SCORE_W + 2*BCD_W +: BCD_W],
                                      sh_shift[SCORE_W + 1*BCD_W +: BCD_W]);
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_out) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            one_q   <= '0;
            ten_q   <= '0;
            hun_q   <= '0;
            en_q    <= 3'b001;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            one_q   <= one_d;
            ten_q   <= ten_d;
            hun_q   <= hun_d;
            en_q    <= en_d;
            done_q  <= done_d;
        end
    end

    assign bus.ready    = (state_q == IDLE);
    assign bus.busy     = (state_q == CONV);
    assign bus.done     = done_q;
    assign bus.one      = one_q;
    assign bus.ten      = ten_q;
    assign bus.hun      = hun_q;
    assign bus.digit_en = en_q;

endmodule

// File: tb/tb_score_bcd_ctrl.sv
// tb/tb_score_bcd_ctrl.sv - scoreboard bench for score_bcd_ctrl in auto and request modes
module tb_score_bcd_ctrl;

    typedef struct {
        logic [3:0] hun;
        logic [3:0] ten;
        logic [3:0] one;
        logic [2:0] en;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q_a[$];
    exp_t q_m[$];

    score_bcd_ctrl_if bus_a ();
    score_bcd_ctrl_if bus_m ();

    score_bcd_ctrl #(.AUTO_UPDATE(1'b1), .BLANK_LZ(1'b1)) dut_a (
        .clk_out (clk),
        .rst_n   (rst_n),
        .bus     (bus_a.slave)
    );

    score_bcd_ctrl #(.AUTO_UPDATE(1'b0), .BLANK_LZ(1'b1)) dut_m (
        .clk_out (clk),
        .rst_n   (rst_n),
        .bus     (bus_m.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t make_exp(input int v, input int due);
        exp_t e;
        e.hun = 4'(v / 100);
        e.ten = 4'((v / 10) % 10);
        e.one = 4'(v % 10);
        e.en  = {e.hun != 0, (e.hun != 0) || (e.ten != 0), 1'b1};
        e.due = due;
        return e;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus_a.done === 1'b1) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_done", bus_a.done, 0);
            end else begin
                e = q_a.pop_front();
                check("a_hun", bus_a.hun, e.hun);
                check("a_ten", bus_a.ten, e.ten);
                check("a_one", bus_a.one, e.one);
                check("a_digit_en", bus_a.digit_en, e.en);
                check("a_latency", cyc, e.due);
            end
        end
        if (bus_m.done === 1'b1) begin
            if (q_m.size() == 0) begin
                check("m_unexpected_done", bus_m.done, 0);
            end else begin
                e = q_m.pop_front();
                check("m_hun", bus_m.hun, e.hun);
                check("m_ten", bus_m.ten, e.ten);
                check("m_one", bus_m.one, e.one);
                check("m_digit_en", bus_m.digit_en, e.en);
                check("m_latency", cyc, e.due);
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        bus_a.score = 8'd0;
        bus_a.req   = 1'b0;
        bus_m.score = 8'd0;
        bus_m.req   = 1'b0;
        step(2);
        check("rst_a_digits", {bus_a.hun, bus_a.ten, bus_a.one}, 0);
        check("rst_a_en", bus_a.digit_en, 3'b001);
        check("rst_a_done", bus_a.done, 0);
        check("rst_a_ready", bus_a.ready, 1);
        check("rst_m_digits", {bus_m.hun, bus_m.ten, bus_m.one}, 0);
        check("rst_m_ready", bus_m.ready, 1);

        rst_n = 1'b1;
        step(4);
        check("idle_a_ready", bus_a.ready, 1);
        check("idle_a_busy", bus_a.busy, 0);
        check("idle_a_digits", {bus_a.hun, bus_a.ten, bus_a.one}, 0);
        check("idle_a_en", bus_a.digit_en, 3'b001);

        // 0 -> 255: busy for exactly 8 cycles, then one DONE cycle
        bus_a.score = 8'd255;
        q_a.push_back(make_exp(255, cyc + 9));
        for (int k = 1; k <= 8; k++) begin
            step(1);
            check("conv_a_busy", bus_a.busy, 1);
            check("conv_a_ready", bus_a.ready, 0);
        end
        step(1);
        check("done_a_busy", bus_a.busy, 0);
        check("done_a_ready", bus_a.ready, 0);
        step(1);
        check("post_a_ready", bus_a.ready, 1);
        check("post_a_done", bus_a.done, 0);
        check("post_a_en", bus_a.digit_en, 3'b111);

        bus_a.score = 8'd7;
        q_a.push_back(make_exp(7, cyc + 9));
        step(10);
        bus_a.score = 8'd40;
        q_a.push_back(make_exp(40, cyc + 9));
        step(10);
        check("hold_a_digits", {bus_a.hun, bus_a.ten, bus_a.one}, 12'h040);
        check("hold_a_en", bus_a.digit_en, 3'b011);

        // score changes mid-conversion: first result is the sampled value, then it re-converges
        bus_a.score = 8'd123;
        q_a.push_back(make_exp(123, cyc + 9));
        step(3);
        bus_a.score = 8'd200;
        q_a.push_back(make_exp(200, cyc + 16));
        step(17);
        check("conv_a_ready", bus_a.ready, 1);
        check("conv_a_digits", {bus_a.hun, bus_a.ten, bus_a.one}, 12'h200);

        // request mode: reqs during CONV and DONE are dropped
        bus_m.score = 8'd99;
        bus_m.req   = 1'b1;
        q_m.push_back(make_exp(99, cyc + 9));
        step(1);
        bus_m.req = 1'b0;
        check("m_busy", bus_m.busy, 1);
        step(2);
        bus_m.score = 8'd100;
        bus_m.req   = 1'b1;
        step(1);
        bus_m.req = 1'b0;
        step(5);
        bus_m.req = 1'b1;
        step(1);
        bus_m.req = 1'b0;
        check("m_ready_back", bus_m.ready, 1);
        step(3);
        check("m_no_retrigger", bus_m.busy, 0);
        bus_m.score = 8'd5;
        step(3);
        check("m_no_auto", bus_m.busy, 0);
        bus_m.score = 8'd100;
        bus_m.req   = 1'b1;
        q_m.push_back(make_exp(100, cyc + 9));
        step(1);
        bus_m.req = 1'b0;
        step(10);
        check("m_final_digits", {bus_m.hun, bus_m.ten, bus_m.one}, 12'h100);

        // reset in the middle of a conversion: no done, digits cleared
        bus_a.score = 8'd255;
        step(5);
        check("abort_a_busy_before", bus_a.busy, 1);
        rst_n       = 1'b0;
        bus_a.score = 8'd0;
        step(1);
        rst_n = 1'b1;
        check("abort_a_ready", bus_a.ready, 1);
        check("abort_a_digits", {bus_a.hun, bus_a.ten, bus_a.one}, 0);
        check("abort_a_en", bus_a.digit_en, 3'b001);
        check("abort_a_done", bus_a.done, 0);
        step(12);
        check("abort_a_idle", bus_a.busy, 0);
        check("abort_a_digits_hold", {bus_a.hun, bus_a.ten, bus_a.one}, 0);

        check("a_queue_empty", q_a.size(), 0);
        check("m_queue_empty", q_m.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
